ps2_rx_fifo: RTL and testbench

PS/2 device-to-host receiver with parametrised input deglitch filters and frame checking (start, odd parity, stop, inter-bit timeout). Valid scan-code bytes go into a first-word-fall-through FIFO that is drained with a valid/ready handshake. It sits between the board PS/2 pins and the keyboard decode / display logic. It replaces the fixed 24-bit shift-out receiver.

---
 rtl/ps2_rx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with deglitch filters, frame checking
// (start, odd parity, stop, inter-bit timeout) and a first-word-fall-through byte FIFO
// drained by a valid/ready handshake.
//
// Optional build macro: PS2_PARITY_CHECK_EN
//   defined   -> frames with a parity mismatch are dropped and o_ParityErr pulses
//   undefined -> the parity bit is clocked through but ignored; o_ParityErr stays 0
//
// Handshake: o_Valid is high whenever the FIFO holds a byte and o_Data shows the head
// entry; a pop happens on every rising edge of i_clk where o_Valid and i_Ready are both
// high. o_Valid does not depend on i_Ready, and i_Ready is ignored while o_Valid is low.
//
// Debug: o_state exposes the frame FSM (0=IDLE, 1=DATA, 2=PARITY, 3=STOP).
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_PS2C,
  input  logic                            i_PS2D,
  output logic [7:0]                      o_Data,
  output logic                            o_Valid,
  input  logic                            i_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Level,
  output logic                            o_FrameErr,
  output logic                            o_ParityErr,
  output logic                            o_Overflow,
  output logic [1:0]                      o_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Deglitch filters
  // ---------------------------------------------------------------------------
  logic [FILTER_LEN-1:0] c_sr, d_sr;
  logic [FILTER_LEN-1:0] c_sr_nxt, d_sr_nxt;
  logic                  c_filt, d_filt, c_prev;
  logic                  fall;

  // The level decision looks at the register contents including this cycle's
  // sample, so a clean pin change reaches the filtered level FILTER_LEN cycles later.
  assign c_sr_nxt = {c_sr[FILTER_LEN-2:0], i_PS2C};
  assign d_sr_nxt = {d_sr[FILTER_LEN-2:0], i_PS2D};

  // Shift both pins in and switch each filtered level only on a unanimous history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c_sr   <= '1;
      d_sr   <= '1;
      c_filt <= 1'b1;
      d_filt <= 1'b1;
      c_prev <= 1'b1;
    end else begin
      c_sr   <= c_sr_nxt;
      d_sr   <= d_sr_nxt;
      if (&c_sr_nxt)       c_filt <= 1'b1;
      else if (~|c_sr_nxt) c_filt <= 1'b0;
      if (&d_sr_nxt)       d_filt <= 1'b1;
      else if (~|d_sr_nxt) d_filt <= 1'b0;
      c_prev <= c_filt;
    end
  end

  assign fall = c_prev & ~c_filt;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_inc;
  logic          timeout_hit;
  logic          parity_ok;
  logic          push_req;
  logic          frame_err_q;
  logic          parity_err_q;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Saturating increment so a long idle gap can never wrap back below the limit.
  assign tmo_inc     = (tmo_cnt == TW'(TIMEOUT_CYC)) ? tmo_cnt : tmo_cnt + TW'(1);
  assign timeout_hit = (state != S_IDLE) && !fall && (tmo_inc == TW'(TIMEOUT_CYC));

  // The byte is written on the very cycle the stop-bit fall is seen.
  assign push_req = fall && (state == S_STOP) && d_filt && parity_ok;

  // Walk the 11-bit frame on filtered falls; a timeout abandons the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      tmo_cnt      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      if (fall)                  tmo_cnt <= '0;
      else if (state != S_IDLE)  tmo_cnt <= tmo_inc;
      case (state)
        S_IDLE: begin
          // A high data line on a fall is not a start bit; ignore it quietly.
          if (fall && !d_filt) begin
            state   <= S_DATA;
            bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (fall) begin
            shreg   <= {d_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= d_filt;
`endif
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (fall) begin
            state <= S_IDLE;
            if (!d_filt)         frame_err_q  <= 1'b1;
            else if (!parity_ok) parity_err_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (timeout_hit) begin
        frame_err_q <= 1'b1;
        state       <= S_IDLE;
      end
    end
  end

  assign o_FrameErr  = frame_err_q;
  assign o_ParityErr = parity_err_q;
  assign o_state     = state;

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, pop, push_acc, ovf_q;

  assign full     = (count == LW'(FIFO_DEPTH));
  assign pop      = o_Valid & i_Ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign push_acc = push_req & (!full | pop);

  // Storage array; entries are only visible through o_Data while o_Valid is high.
  always_ff @(posedge i_clk) begin
    if (push_acc) mem[wr_ptr] <= shreg;
  end

  // Pointers, occupancy and the overflow pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= push_req & full & !pop;
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_Valid    = (count != '0);
  assign o_Data     = o_Valid ? mem[rd_ptr] : 8'h00;
  assign o_Level    = count;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized and directed frames against a queue-based model of the
// receiver (frame outcome rules plus a bounded byte queue).
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int HALF  = 20;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          ps2c, ps2d, ready;
  logic [7:0]    o_data;
  logic          o_valid, o_frame_err, o_parity_err, o_overflow;
  logic [LW-1:0] o_level;
  logic [1:0]    o_state;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_PS2C(ps2c), .i_PS2D(ps2d),
    .o_Data(o_data), .o_Valid(o_valid), .i_Ready(ready), .o_Level(o_level),
    .o_FrameErr(o_frame_err), .o_ParityErr(o_parity_err), .o_Overflow(o_overflow),
    .o_state(o_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         exp_fe = 0, exp_pe = 0, exp_ovf = 0;
  int         fe_cnt = 0, pe_cnt = 0, ovf_cnt = 0, excl_viol = 0;
  int         cyc = 0, last_fe_cyc = 0, last_fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor: counts every cycle each error output is high.
  always @(posedge clk) begin
    cyc++;
    if (o_frame_err === 1'b1) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (o_parity_err === 1'b1) pe_cnt++;
    if (o_overflow === 1'b1) ovf_cnt++;
    if ((int'(o_frame_err) + int'(o_parity_err) + int'(o_overflow)) > 1) excl_viol++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cyc(HALF);
    ps2c = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2c = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr = make_frame(b, bad_par, bad_stop);
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    ps2d = 1'b1;
    wait_cyc(HALF);
  endtask

  // Reference model: outcome of one complete frame.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop)                     exp_fe++;
    else if (bad_par && PAR_EN)       exp_pe++;
    else if (exp_q.size() == DEPTH)   exp_ovf++;
    else                              exp_q.push_back(b);
  endtask

  task automatic check_status(input string tag);
    wait_cyc(FL + 4);
    check({tag, "_level"}, 32'(o_level), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(o_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(o_data), 32'(exp_q[0]));
    check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
    check({tag, "_parity_err"}, 32'(pe_cnt), 32'(exp_pe));
    check({tag, "_overflow"}, 32'(ovf_cnt), 32'(exp_ovf));
  endtask

  task automatic full_frame(input string tag, input logic [7:0] b, input bit bad_par,
                            input bit bad_stop);
    send_frame(b, bad_par, bad_stop, 11);
    model_frame(b, bad_par, bad_stop);
    check_status(tag);
  endtask

  // Pops n entries, one i_Ready cycle per byte.
  task automatic drain(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check("drain_valid", 32'(o_valid), 32'd1);
      check("drain_data", 32'(o_data), 32'(e));
      ready = 1'b1;
      wait_cyc(1);
      ready = 1'b0;
    end
    check("drain_level", 32'(o_level), 32'(exp_q.size()));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] fr;
    int          dt;
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; ready = 1'b0;
    wait_cyc(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_errs", 32'({o_frame_err, o_parity_err, o_overflow}), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // 0x1C with exact push latency on the stop-bit fall.
    fr = make_frame(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(fr[i]);
    ps2d = 1'b1;
    wait_cyc(HALF);
    ps2c = 1'b0;
    wait_cyc(FL);
    check("lat_valid_before", 32'(o_valid), 32'd0);
    wait_cyc(1);
    check("lat_valid_after", 32'(o_valid), 32'd1);
    check("lat_data", 32'(o_data), 32'h1C);
    wait_cyc(HALF - FL - 1);
    ps2c = 1'b1;
    wait_cyc(HALF);
    exp_q.push_back(8'h1C);
    check_status("first");
    drain(1);

    // Back-to-back make/break sequence.
    full_frame("e0", 8'hE0, 1'b0, 1'b0);
    full_frame("f0", 8'hF0, 1'b0, 1'b0);
    full_frame("1c", 8'h1C, 1'b0, 1'b0);
    drain(3);

    // Parity flipped.
    full_frame("par", 8'h1C, 1'b1, 1'b0);
    drain(exp_q.size());

    // Bad stop bit.
    full_frame("stop", 8'hA5, 1'b0, 1'b1);

    // Timeout after start + 4 data bits.
    send_frame(8'h0F, 1'b0, 1'b0, 5);
    wait_cyc(250 - HALF);
    exp_fe++;
    check_status("tmo");
    dt = last_fe_cyc - last_fall_cyc;
    check("tmo_when", 32'(dt >= TMO && dt <= TMO + FL + 4), 32'd1);
    check("tmo_state", 32'(o_state), 32'd0);
    full_frame("5a", 8'h5A, 1'b0, 1'b0);
    drain(1);

    // Overflow with a 4-entry FIFO.
    for (int i = 1; i <= 5; i++) full_frame("ovf", 8'(i), 1'b0, 1'b0);
    check("ovf_level", 32'(o_level), 32'(DEPTH));
    drain(4);

    // 3-cycle clock glitch with data low must not start a frame.
    ps2d = 1'b0;
    wait_cyc(HALF);
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(HALF);
    ps2d = 1'b1;
    wait_cyc(HALF);
    check("glitch_state", 32'(o_state), 32'd0);
    full_frame("glitch", 8'h3B, 1'b0, 1'b0);

    // Reset in the middle of a frame (FIFO still holds 0x3B).
    send_frame(8'h77, 1'b0, 1'b0, 6);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    exp_q.delete();
    wait_cyc(1);
    check("mid_rst_level", 32'(o_level), 32'd0);
    check("mid_rst_state", 32'(o_state), 32'd0);
    wait_cyc(250);
    check_status("mid_rst");
    full_frame("29", 8'h29, 1'b0, 1'b0);
    drain(1);

    // Randomized frames with random faults and random partial drains.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      int         r;
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 5);
      full_frame("rnd", b, r == 0, r == 1);
      if ($urandom_range(0, 2) == 0) drain($urandom_range(0, exp_q.size()));
    end
    drain(exp_q.size());
    check("excl", 32'(excl_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Run-time bound.
  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
